// File: rtl/disp_shift_if.sv
// Bundle between the PDM dimmer / frame source and the serial display driver stage.
// The master side supplies frames and blank; the slave side drives the HV5812-class pins.
interface disp_shift_if #(
  parameter int WIDTH = 20
);
  logic [WIDTH-1:0] disp_data;
  logic             disp_load;
  logic             disp_blank;
  logic             sr_clk;
  logic             sr_data;
  logic             sr_load;
  logic             sr_blank;
  logic             busy;
  logic             done;

  modport master (
    output disp_data, disp_load, disp_blank,
    input  sr_clk, sr_data, sr_load, sr_blank, busy, done
  );

  modport slave (
    input  disp_data, disp_load, disp_blank,
    output sr_clk, sr_data, sr_load, sr_blank, busy, done
  );
endinterface

// File: rtl/disp_shift.sv
// Serial display driver: shifts a WIDTH-bit frame MSB-first to an external shift/latch
// driver, pulses the latch, and holds one pending update while a frame is in flight.
module disp_shift #(
  parameter int WIDTH = 20,
  parameter int DIV   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  disp_shift_if.slave   bus
);

  localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BC_W = $clog2(WIDTH);
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(DIV - 1);
  localparam logic [BC_W-1:0] BC_MAX = BC_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHLO,
    SHHI,
    LATCH
  } state_t;

  state_t            state_q, state_n;
  logic [PH_W-1:0]   phase_q, phase_n;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_n;
  logic              pend_flag_q, pend_flag_n;
  logic [WIDTH-1:0]  pend_word_q, pend_word_n;
  logic [WIDTH-1:0]  sreg_q, sreg_n;
  logic [WIDTH-1:0]  start_word;
  logic              sr_clk_q, sr_clk_n;
  logic              sr_data_q, sr_data_n;
  logic              sr_load_q, sr_load_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              sr_blank_q;

  // A request arriving in the final latch cycle is taken directly so held loads run gap-free.
  always_comb begin
    state_n     = state_q;
    phase_n     = phase_q;
    bitcnt_n    = bitcnt_q;
    pend_flag_n = pend_flag_q;
    pend_word_n = pend_word_q;
    sreg_n      = sreg_q;
    sr_clk_n    = sr_clk_q;
    sr_data_n   = sr_data_q;
    sr_load_n   = sr_load_q;
    busy_n      = busy_q;
    done_n      = 1'b0;
    start_word  = bus.disp_load ? bus.disp_data : pend_word_q;

    if (state_q != IDLE && bus.disp_load) begin
      pend_word_n = bus.disp_data;
      pend_flag_n = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.disp_load) begin
          state_n   = SHLO;
          phase_n   = PH_MAX;
          bitcnt_n  = BC_MAX;
          sreg_n    = bus.disp_data;
          sr_data_n = bus.disp_data[WIDTH-1];
          sr_clk_n  = 1'b0;
          sr_load_n = 1'b0;
          busy_n    = 1'b1;
        end
      end

      SHLO: begin
        if (phase_q == '0) begin
          state_n  = SHHI;
          phase_n  = PH_MAX;
          sr_clk_n = 1'b1;
        end else begin
          phase_n = phase_q - PH_W'(1);
        end
      end

      SHHI: begin
        if (phase_q == '0) begin
          sr_clk_n = 1'b0;
          phase_n  = PH_MAX;
          if (bitcnt_q != '0) begin
            state_n   = SHLO;
            bitcnt_n  = bitcnt_q - BC_W'(1);
            // Rotate rather than zero-fill; the wrapped bits are never shifted out.
            sreg_n    = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
            sr_data_n = sreg_q[WIDTH-2];
          end else begin
            state_n   = LATCH;
            sr_data_n = 1'b0;
            sr_load_n = 1'b1;
          end
        end else begin
          phase_n = phase_q - PH_W'(1);
        end
      end

      LATCH: begin
        if (phase_q == '0) begin
          sr_load_n   = 1'b0;
          done_n      = 1'b1;
          pend_flag_n = 1'b0;
          if (pend_flag_q || bus.disp_load) begin
            state_n   = SHLO;
            phase_n   = PH_MAX;
            bitcnt_n  = BC_MAX;
            sreg_n    = start_word;
            sr_data_n = start_word[WIDTH-1];
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          phase_n = phase_q - PH_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bitcnt_q    <= '0;
      pend_flag_q <= 1'b0;
      sr_clk_q    <= 1'b0;
      sr_data_q   <= 1'b0;
      sr_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sr_blank_q  <= 1'b1;
    end else begin
      state_q     <= state_n;
      phase_q     <= phase_n;
      bitcnt_q    <= bitcnt_n;
      pend_flag_q <= pend_flag_n;
      sr_clk_q    <= sr_clk_n;
      sr_data_q   <= sr_data_n;
      sr_load_q   <= sr_load_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      sr_blank_q  <= bus.disp_blank;
    end
  end

  // Frame words are qualified by the control state, so they carry no reset.
  always_ff @(posedge clk) begin
    sreg_q      <= sreg_n;
    pend_word_q <= pend_word_n;
  end

  assign bus.sr_clk   = sr_clk_q;
  assign bus.sr_data  = sr_data_q;
  assign bus.sr_load  = sr_load_q;
  assign bus.sr_blank = sr_blank_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_disp_shift.sv
// Bench for disp_shift: frame scoreboard on the default instance plus a WIDTH=2/DIV=1 instance.
module tb_disp_shift;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  disp_shift_if #(.WIDTH(20)) bus ();
  disp_shift_if #(.WIDTH(2))  bus6 ();

  disp_shift #(.WIDTH(20), .DIV(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  disp_shift #(.WIDTH(2), .DIV(1)) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  int tests = 0;
  int fails = 0;
  logic [19:0] exp_q[$];

  // Scoreboard: rebuild each frame from sr_clk rising edges, compare on done.
  logic        mon_pc;
  logic [19:0] mon_obs;
  int          mon_nbits;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_pc    = 1'b0;
      mon_obs   = '0;
      mon_nbits = 0;
    end else begin
      if (bus.sr_clk && !mon_pc) begin
        mon_obs   = {mon_obs[18:0], bus.sr_data};
        mon_nbits = mon_nbits + 1;
      end
      mon_pc = bus.sr_clk;
      if (bus.done) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_frame: got frame %h (%0d bits), required none", mon_obs, mon_nbits);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          if (mon_obs !== e || mon_nbits != 20) begin
            fails++;
            $display("FAIL sb_frame: got %h (%0d bits), required %h (20 bits)", mon_obs, mon_nbits, e);
          end
        end
        mon_nbits = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.disp_data = '0;  bus.disp_load = 1'b0;  bus.disp_blank = 1'b0;
    bus6.disp_data = '0; bus6.disp_load = 1'b0; bus6.disp_blank = 1'b0;
    repeat (3) tick();
    tests++;
    if (bus.sr_blank !== 1'b1) begin
      fails++; $display("FAIL rst_blank: got %b required 1", bus.sr_blank);
    end
    tests++;
    if ({bus.sr_clk, bus.sr_data, bus.sr_load, bus.busy, bus.done} !== 5'b0) begin
      fails++; $display("FAIL rst_outs: got %b required 00000",
                        {bus.sr_clk, bus.sr_data, bus.sr_load, bus.busy, bus.done});
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.sr_blank !== 1'b1) begin
      fails++; $display("FAIL rel_blank_hold: got %b required 1", bus.sr_blank);
    end
    tick();
    tests++;
    if (bus.sr_blank !== 1'b0) begin
      fails++; $display("FAIL rel_blank: got %b required 0", bus.sr_blank);
    end
    tests++;
    if ({bus.sr_clk, bus.sr_data, bus.sr_load, bus.busy, bus.done} !== 5'b0) begin
      fails++; $display("FAIL rel_outs: got %b required 00000",
                        {bus.sr_clk, bus.sr_data, bus.sr_load, bus.busy, bus.done});
    end
  endtask

  task automatic test_blank();
    bus.disp_blank = 1'b1;
    #1;
    tests++;
    if (bus.sr_blank !== 1'b0) begin
      fails++; $display("FAIL blank_comb: got %b required 0", bus.sr_blank);
    end
    tick();
    tests++;
    if (bus.sr_blank !== 1'b1) begin
      fails++; $display("FAIL blank_rise: got %b required 1", bus.sr_blank);
    end
    bus.disp_blank = 1'b0;
    tick();
    tests++;
    if (bus.sr_blank !== 1'b0) begin
      fails++; $display("FAIL blank_fall: got %b required 0", bus.sr_blank);
    end
  endtask

  task automatic test_single();
    logic pc;
    int   rises;
    bus.disp_data = 20'hA5F0C; bus.disp_load = 1'b1;
    exp_q.push_back(20'hA5F0C);
    tick();
    bus.disp_load = 1'b0; bus.disp_data = 20'hFFFFF;
    pc = 1'b0; rises = 0;
    for (int k = 1; k <= 168; k++) begin
      logic er, rise;
      er   = (k >= 5 && k <= 157 && (k - 5) % 8 == 0);
      rise = bus.sr_clk && !pc;
      tests++;
      if (rise !== er) begin
        fails++; $display("FAIL t2_rise: cycle %0d got %b required %b", k, rise, er);
      end
      tests++;
      if (bus.busy !== (k <= 164)) begin
        fails++; $display("FAIL t2_busy: cycle %0d got %b required %b", k, bus.busy, k <= 164);
      end
      tests++;
      if (bus.sr_load !== (k >= 161 && k <= 164)) begin
        fails++; $display("FAIL t2_load: cycle %0d got %b required %b", k, bus.sr_load, k >= 161 && k <= 164);
      end
      tests++;
      if (bus.done !== (k == 165)) begin
        fails++; $display("FAIL t2_done: cycle %0d got %b required %b", k, bus.done, k == 165);
      end
      if (k >= 161 && k <= 164) begin
        tests++;
        if (bus.sr_data !== 1'b0) begin
          fails++; $display("FAIL t2_latch_data: cycle %0d got %b required 0", k, bus.sr_data);
        end
      end
      if (rise) rises++;
      pc = bus.sr_clk;
      tick();
    end
    tests++;
    if (rises != 20) begin
      fails++; $display("FAIL t2_rises: got %0d required 20", rises);
    end
  endtask

  task automatic test_queue();
    int dones;
    bus.disp_data = 20'h0F0F0; bus.disp_load = 1'b1;
    exp_q.push_back(20'h0F0F0);
    exp_q.push_back(20'h22222);
    tick();
    bus.disp_load = 1'b0;
    dones = 0;
    for (int k = 1; k <= 350; k++) begin
      tests++;
      if (bus.busy !== (k <= 328)) begin
        fails++; $display("FAIL t3_busy: cycle %0d got %b required %b", k, bus.busy, k <= 328);
      end
      tests++;
      if (bus.done !== (k == 165 || k == 329)) begin
        fails++; $display("FAIL t3_done: cycle %0d got %b required %b", k, bus.done, k == 165 || k == 329);
      end
      if (bus.done) dones++;
      case (k)
        40: begin bus.disp_data = 20'h11111; bus.disp_load = 1'b1; end
        60: begin bus.disp_data = 20'h22222; bus.disp_load = 1'b1; end
        default: bus.disp_load = 1'b0;
      endcase
      tick();
    end
    tests++;
    if (dones != 2) begin
      fails++; $display("FAIL t3_dones: got %0d required 2", dones);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    bus.disp_data = 20'h3CA5F; bus.disp_load = 1'b1;
    exp_q.push_back(20'h3CA5F);
    exp_q.push_back(20'h3CA5F);
    exp_q.push_back(20'h96E01);
    tick();
    dones = 0;
    for (int k = 1; k <= 510; k++) begin
      tests++;
      if (bus.busy !== (k <= 492)) begin
        fails++; $display("FAIL t4_busy: cycle %0d got %b required %b", k, bus.busy, k <= 492);
      end
      tests++;
      if (bus.done !== (k == 165 || k == 329 || k == 493)) begin
        fails++; $display("FAIL t4_done: cycle %0d got %b required %b", k, bus.done,
                          k == 165 || k == 329 || k == 493);
      end
      if (bus.done) dones++;
      if (k == 165) bus.disp_data = 20'h96E01;
      if (k == 329) bus.disp_load = 1'b0;
      tick();
    end
    tests++;
    if (dones != 3) begin
      fails++; $display("FAIL t4_dones: got %0d required 3", dones);
    end
  endtask

  task automatic test_reset_mid();
    bus.disp_data = 20'h5A3C9; bus.disp_load = 1'b1;
    exp_q.push_back(20'h5A3C9);
    tick();
    bus.disp_load = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      tests++;
      if (bus.sr_load !== 1'b0) begin
        fails++; $display("FAIL t5_preload: cycle %0d got %b required 0", k, bus.sr_load);
      end
      tick();
    end
    #2;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    tests++;
    if ({bus.sr_clk, bus.sr_data, bus.sr_load, bus.busy, bus.done, bus.sr_blank} !== 6'b000001) begin
      fails++; $display("FAIL t5_async: got %b required 000001",
                        {bus.sr_clk, bus.sr_data, bus.sr_load, bus.busy, bus.done, bus.sr_blank});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (bus.sr_load !== 1'b0 || bus.done !== 1'b0) begin
        fails++; $display("FAIL t5_hold: got load=%b done=%b required 0 0", bus.sr_load, bus.done);
      end
    end
    rst_n = 1'b1;
    tick();
    bus.disp_data = 20'hC3A96; bus.disp_load = 1'b1;
    exp_q.push_back(20'hC3A96);
    tick();
    bus.disp_load = 1'b0;
    for (int k = 1; k <= 168; k++) begin
      tests++;
      if (bus.busy !== (k <= 164) || bus.done !== (k == 165)) begin
        fails++; $display("FAIL t5_frame: cycle %0d got busy=%b done=%b required %b %b",
                          k, bus.busy, bus.done, k <= 164, k == 165);
      end
      tick();
    end
  endtask

  task automatic test_div1();
    logic [7:0] e_data, e_clk, e_load, e_busy, e_done;
    //            k: 76543210
    e_data = 8'b00000110;
    e_clk  = 8'b00010100;
    e_load = 8'b00100000;
    e_busy = 8'b00111110;
    e_done = 8'b01000000;
    bus6.disp_data = 2'b10; bus6.disp_load = 1'b1;
    tick();
    bus6.disp_load = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tests++;
      if ({bus6.sr_data, bus6.sr_clk, bus6.sr_load, bus6.busy, bus6.done} !==
          {e_data[k], e_clk[k], e_load[k], e_busy[k], e_done[k]}) begin
        fails++; $display("FAIL t6_cycle: cycle %0d got data/clk/load/busy/done=%b required %b", k,
                          {bus6.sr_data, bus6.sr_clk, bus6.sr_load, bus6.busy, bus6.done},
                          {e_data[k], e_clk[k], e_load[k], e_busy[k], e_done[k]});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_blank();
    test_single();
    test_queue();
    test_back_to_back();
    test_reset_mid();
    test_div1();
    repeat (2) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL sb_drain: got %0d frames outstanding required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
